// File: rtl/typing_round_ctrl.sv
// Player-activity controller for the typing game: two-slot word buffer, key checking
// against the current letter, score/lives bookkeeping and an optional per-word timeout.
module typing_round_ctrl #(
  parameter int LETTERS = 4,
  parameter int CODE_W  = 5,
  parameter int SCORE_W = 8,
  parameter int LIVES   = 3,
  parameter int TIMEOUT = 0,
  localparam int WORD_W  = LETTERS * CODE_W,
  localparam int IDX_W   = $clog2(LETTERS + 1),
  localparam int LIVES_W = $clog2(LIVES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CODE_W-1:0]  keystroke,
  input  logic               keyReleased,
  input  logic               startGame,
  input  logic [WORD_W-1:0]  wordIn,
  input  logic               wordValid,
  output logic               wordReq,
  output logic [WORD_W-1:0]  currentWord,
  output logic [WORD_W-1:0]  nextWord,
  output logic [IDX_W-1:0]   currentState,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic               swstart,
  output logic               wordComplete,
  output logic               gameOver,
  output logic [1:0]         dbg_state
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CODE_W-1:0] NULL_CODE = '1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_TYPE = 2'd2, S_OVER = 2'd3} state_t;

  state_t             state_q, state_d;
  logic               kr_q;
  logic [WORD_W-1:0]  cur_word_q, cur_word_d, next_word_q, next_word_d;
  logic               cur_valid_q, cur_valid_d, next_valid_q, next_valid_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               done_q, done_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic               key_ok, correct, wrong, expire, word_last, accept;
  logic [IDX_W-1:0]   idx_inc;
  logic [SCORE_W:0]   score_sum;

  // Letter i of a word; indexes past the last letter read as NULL.
  function automatic logic [CODE_W-1:0] letter_at(input logic [WORD_W-1:0] w, input int i);
    letter_at = NULL_CODE;
    for (int k = 0; k < LETTERS; k++)
      if (k == i) letter_at = w[(LETTERS-1-k)*CODE_W +: CODE_W];
  endfunction

  // Word handshake: a word transfers on any edge where wordValid && wordReq; the source
  // must hold wordIn stable while wordValid is high, and wordReq never depends on wordValid.
  assign wordReq = ((state_q == S_FILL) || (state_q == S_TYPE)) && !next_valid_q;
  assign accept  = wordValid && wordReq && (letter_at(wordIn, 0) != NULL_CODE);

  assign key_ok    = keyReleased && !kr_q && (keystroke != NULL_CODE) && (state_q == S_TYPE);
  assign correct   = key_ok && (keystroke == letter_at(cur_word_q, int'(idx_q)));
  assign wrong     = key_ok && !correct;
  assign expire    = (TIMEOUT != 0) && (state_q == S_TYPE) && !correct &&
                     (timer_q == TMR_W'(TIMEOUT - 1));
  assign idx_inc   = idx_q + 1'b1;
  assign word_last = correct && ((idx_inc == IDX_W'(LETTERS)) ||
                                 (letter_at(cur_word_q, int'(idx_inc)) == NULL_CODE));
  assign score_sum = {1'b0, score_q} + {{(SCORE_W + 1 - IDX_W){1'b0}}, idx_inc};

  always_comb begin
    state_d      = state_q;
    cur_word_d   = cur_word_q;
    cur_valid_d  = cur_valid_q;
    next_word_d  = next_word_q;
    next_valid_d = next_valid_q;
    idx_d        = idx_q;
    score_d      = score_q;
    lives_d      = lives_q;
    timer_d      = timer_q;
    done_d       = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (startGame) begin
          state_d      = S_FILL;
          lives_d      = LIVES_W'(LIVES);
          score_d      = '0;
          cur_word_d   = '0;
          cur_valid_d  = 1'b0;
          next_word_d  = '0;
          next_valid_d = 1'b0;
          idx_d        = '0;
          timer_d      = '0;
        end
      end
      S_FILL: begin
        if (cur_valid_q) begin
          state_d = S_TYPE;
          idx_d   = '0;
          timer_d = '0;
        end
      end
      default: begin
        if (TIMEOUT != 0) timer_d = timer_q + 1'b1;
        if (correct) begin
          idx_d   = idx_inc;
          timer_d = '0;
        end
        if (wrong || expire) lives_d = lives_q - 1'b1;
        // Losing the last life freezes the round where it stands.
        if ((wrong || expire) && (lives_q == LIVES_W'(1))) begin
          state_d = S_OVER;
        end else if (word_last || expire) begin
          done_d = word_last;
          if (word_last) score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          cur_word_d   = next_word_q;
          cur_valid_d  = next_valid_q;
          next_word_d  = '0;
          next_valid_d = 1'b0;
          idx_d        = '0;
          timer_d      = '0;
          state_d      = next_valid_q ? S_TYPE : S_FILL;
        end
      end
    endcase
    // An arriving word takes whichever slot is free after this cycle's advance.
    if (accept) begin
      if (!cur_valid_d) begin
        cur_word_d  = wordIn;
        cur_valid_d = 1'b1;
      end else begin
        next_word_d  = wordIn;
        next_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      kr_q         <= 1'b1;
      cur_word_q   <= '0;
      cur_valid_q  <= 1'b0;
      next_word_q  <= '0;
      next_valid_q <= 1'b0;
      idx_q        <= '0;
      score_q      <= '0;
      lives_q      <= LIVES_W'(LIVES);
      done_q       <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      kr_q         <= keyReleased;
      cur_word_q   <= cur_word_d;
      cur_valid_q  <= cur_valid_d;
      next_word_q  <= next_word_d;
      next_valid_q <= next_valid_d;
      idx_q        <= idx_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      done_q       <= done_d;
      timer_q      <= timer_d;
    end
  end

  assign currentWord  = cur_word_q;
  assign nextWord     = next_word_q;
  assign currentState = idx_q;
  assign score        = score_q;
  assign lives        = lives_q;
  assign swstart      = (state_q == S_TYPE);
  assign wordComplete = done_q;
  assign gameOver     = (state_q == S_OVER);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_typing_round_ctrl.sv
// Bench for typing_round_ctrl: directed vector table plus randomized play checked
// against a queue-based model of the game rules.
`timescale 1ns/1ps
module tb_typing_round_ctrl;
  localparam int LETTERS = 4;
  localparam int CODE_W  = 5;
  localparam int LIVES   = 3;
  localparam int TIMEOUT = 20;
  localparam logic [4:0] NUL = 5'h1f;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  keystroke;
  logic        keyReleased;
  logic        startGame;
  logic [19:0] wordIn;
  logic        wordValid;
  logic        wordReq;
  logic [19:0] currentWord, nextWord;
  logic [2:0]  currentState;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        swstart, wordComplete, gameOver;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  typing_round_ctrl #(.LETTERS(4), .CODE_W(5), .SCORE_W(8), .LIVES(3), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .keystroke(keystroke), .keyReleased(keyReleased),
    .startGame(startGame), .wordIn(wordIn), .wordValid(wordValid), .wordReq(wordReq),
    .currentWord(currentWord), .nextWord(nextWord), .currentState(currentState),
    .score(score), .lives(lives), .swstart(swstart), .wordComplete(wordComplete),
    .gameOver(gameOver), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  localparam int PH_IDLE = 0, PH_FILL = 1, PH_TYPE = 2, PH_OVER = 3;
  int          m_phase, m_pos, m_score, m_lives, m_idle;
  bit          m_done, m_prev_kr;
  logic [19:0] m_slots[$];

  function automatic logic [4:0] letter(input logic [19:0] w, input int i);
    logic [19:0] s;
    s = w >> ((LETTERS - 1 - i) * CODE_W);
    return s[4:0];
  endfunction

  function automatic int num_letters(input logic [19:0] w);
    int n = 0;
    while (n < LETTERS && letter(w, n) != NUL) n++;
    return n;
  endfunction

  function automatic bit exp_req();
    return (m_phase == PH_FILL || m_phase == PH_TYPE) && m_slots.size() < 2;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_pos = 0; m_score = 0; m_lives = LIVES; m_idle = 0;
    m_done = 0; m_prev_kr = 1; m_slots.delete();
  endtask

  task automatic model_step();
    bit ev, good, bad, tmo, take;
    logic [19:0] cur;
    if (!reset) begin model_reset(); return; end
    take = exp_req() && wordValid && letter(wordIn, 0) != NUL;
    ev = keyReleased && !m_prev_kr;
    m_prev_kr = keyReleased;
    m_done = 0;
    case (m_phase)
      PH_IDLE, PH_OVER: if (startGame) begin
        m_phase = PH_FILL; m_lives = LIVES; m_score = 0; m_slots.delete(); m_pos = 0; m_idle = 0;
      end
      PH_FILL: if (m_slots.size() > 0) begin m_phase = PH_TYPE; m_pos = 0; m_idle = 0; end
      default: begin
        cur  = m_slots[0];
        good = ev && keystroke != NUL && keystroke == letter(cur, m_pos);
        bad  = ev && keystroke != NUL && !good;
        tmo  = !good && (m_idle + 1 >= TIMEOUT);
        if (bad || tmo) m_lives--;
        if (good) begin m_pos++; m_idle = 0; end else m_idle++;
        if (m_lives == 0) m_phase = PH_OVER;
        else if ((good && m_pos == num_letters(cur)) || tmo) begin
          if (good) begin
            m_done = 1;
            m_score = (m_score + m_pos > 255) ? 255 : m_score + m_pos;
          end
          m_slots.delete(0);
          m_pos = 0; m_idle = 0;
          m_phase = (m_slots.size() > 0) ? PH_TYPE : PH_FILL;
        end
      end
    endcase
    if (take) m_slots.push_back(wordIn);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_currentWord",  currentWord,  m_slots.size() > 0 ? m_slots[0] : 20'd0);
    chk("m_nextWord",     nextWord,     m_slots.size() > 1 ? m_slots[1] : 20'd0);
    chk("m_currentState", currentState, m_pos);
    chk("m_score",        score,        m_score);
    chk("m_lives",        lives,        m_lives);
    chk("m_swstart",      swstart,      m_phase == PH_TYPE);
    chk("m_wordComplete", wordComplete, m_done);
    chk("m_gameOver",     gameOver,     m_phase == PH_OVER);
    chk("m_wordReq",      wordReq,      exp_req());
    chk("m_dbg_state",    dbg_state,    m_phase);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_lives"}, lives, 3);
    chk({tag, "_index"}, currentState, 0);
    chk({tag, "_swstart"}, swstart, 0);
    chk({tag, "_wordReq"}, wordReq, 0);
    chk({tag, "_gameOver"}, gameOver, 0);
    chk({tag, "_word"}, currentWord, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge clk); #1;
    check_model();
  endtask

  task automatic press(input logic [4:0] k);
    keyReleased = 1'b0; cycle();
    keystroke = k; keyReleased = 1'b1; cycle();
  endtask

  function automatic logic [19:0] rand_word();
    logic [19:0] w = '0;
    for (int i = 0; i < LETTERS; i++)
      w = (w << CODE_W) | (($urandom_range(0, 4) == 0) ? 20'(NUL) : 20'($urandom_range(0, 30)));
    return w;
  endfunction

  typedef struct { logic [4:0] key; int idx; int sc; int lv; bit done; } vec_t;

  logic [19:0] w1, w2, w3;
  vec_t tbl[8];
  int   exp_lives[3];

  initial begin
    w1 = {5'b01010, 5'b01110, 5'b01011, 5'b00100};
    w2 = {5'b00001, 5'b00010, NUL, NUL};
    w3 = {5'b00011, 5'b00101, 5'b00110, 5'b00111};
    tbl[0] = '{5'b01010, 1, 0, 3, 1'b0};
    tbl[1] = '{5'b01110, 2, 0, 3, 1'b0};
    tbl[2] = '{5'b01011, 3, 0, 3, 1'b0};
    tbl[3] = '{5'b00100, 0, 4, 3, 1'b1};
    tbl[4] = '{5'b11111, 0, 4, 3, 1'b0};
    tbl[5] = '{5'b00001, 1, 4, 3, 1'b0};
    tbl[6] = '{5'b11111, 1, 4, 3, 1'b0};
    tbl[7] = '{5'b00010, 0, 6, 3, 1'b1};
    exp_lives = '{2, 1, 0};

    // clock/reset
    reset = 1'b0; keystroke = '0; keyReleased = 1'b0; startGame = 1'b0;
    wordIn = '0; wordValid = 1'b0;
    model_reset();
    repeat (3) cycle();
    check_reset_vals("por");
    reset = 1'b1;
    cycle();

    // start and fill both slots
    startGame = 1'b1; cycle(); startGame = 1'b0;
    chk("fill_wordReq", wordReq, 1);
    wordValid = 1'b1; wordIn = w1; cycle();
    chk("fill_cur", currentWord, w1);
    wordIn = w2; cycle();
    chk("type_swstart", swstart, 1);
    chk("type_next", nextWord, w2);
    wordIn = w3; cycle();
    chk("hold_wordReq", wordReq, 0);
    chk("hold_next", nextWord, w2);

    // typing table: full word, padded word, NULL keys
    foreach (tbl[i]) begin
      press(tbl[i].key);
      chk($sformatf("tbl%0d_index", i), currentState, tbl[i].idx);
      chk($sformatf("tbl%0d_score", i), score, tbl[i].sc);
      chk($sformatf("tbl%0d_lives", i), lives, tbl[i].lv);
      chk($sformatf("tbl%0d_done", i), wordComplete, tbl[i].done);
      if (i == 3) chk("adv_cur", currentWord, w2);
      if (i == 4) chk("adv_next_fill", nextWord, w3);
    end
    wordValid = 1'b0;
    chk("after_tbl_cur", currentWord, w3);

    // timeout: nothing typed for TIMEOUT cycles
    repeat (TIMEOUT - 1) cycle();
    chk("tmo_before_lives", lives, 3);
    cycle();
    chk("tmo_lives", lives, 2);
    chk("tmo_score", score, 6);
    chk("tmo_index", currentState, 0);
    chk("tmo_cur", currentWord, 0);
    chk("tmo_swstart", swstart, 0);

    // lose the remaining lives, ignored keys, restart
    wordValid = 1'b1; wordIn = w1; cycle(); wordValid = 1'b0; cycle();
    press(5'b00000); chk("over_l1", lives, 1);
    press(5'b00000); chk("over_l0", lives, 0);
    chk("over_flag", gameOver, 1);
    chk("over_wordReq", wordReq, 0);
    press(5'b01010);
    chk("over_ignored_idx", currentState, 0);
    chk("over_frozen_word", currentWord, w1);
    startGame = 1'b1; cycle(); startGame = 1'b0;
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);
    chk("restart_over", gameOver, 0);
    wordValid = 1'b1; wordIn = w1; cycle(); wordValid = 1'b0; cycle();
    for (int i = 0; i < 3; i++) begin
      press(5'b00000);
      chk($sformatf("wrong%0d_lives", i), lives, exp_lives[i]);
      chk($sformatf("wrong%0d_idx", i), currentState, 0);
    end
    chk("wrong_over", gameOver, 1);

    // randomized play with a mid-game reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        reset = 1'b0; #1;
        check_reset_vals("mid");
        model_reset();
        repeat (2) cycle();
        reset = 1'b1;
      end
      startGame   = ($urandom_range(0, 39) == 0);
      wordValid   = $urandom_range(0, 1);
      wordIn      = ($urandom_range(0, 9) == 0) ? {NUL, 15'($urandom)} : rand_word();
      keyReleased = $urandom_range(0, 1);
      if (m_slots.size() > 0 && $urandom_range(0, 9) < 6) keystroke = letter(m_slots[0], m_pos);
      else keystroke = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
